// File: rtl/uart_pkg.sv
// Shared constants and serializer state type for the buffered UART transmitter.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic [13:0] BAUD_DIV_DEFAULT = 14'd9999;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO with first-word-fall-through read data and registered status flags.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count_n;
  logic                 push;
  logic                 pop;

  // A full FIFO rejects the write even when a pop frees a slot in the same cycle.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + 1'b1;
    end else if (!push && pop) begin
      count_n = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      full     <= (count_n == FULL_CNT);
      empty    <= (count_n == '0);
      overflow <= wr_en && full;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a byte FIFO; frames run back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int           N        = 14,
  parameter logic [N-1:0] BAUD_DIV = N'(BAUD_DIV_DEFAULT),
  parameter int           DEPTH    = 16
) (
  input  logic                   Clk_100M,
  input  logic                   Reset,
  input  logic [7:0]             Wr_Data,
  input  logic                   Wr_En,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic                   Busy,
  output logic                   Tx
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state, state_n;
  logic [N-1:0]         baud_cnt, baud_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] head;
  logic                 pop;
  logic                 tx_bit;
  logic                 baud_done;

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (Clk_100M),
    .rst      (Reset),
    .wr_en    (Wr_En),
    .wr_data  (Wr_Data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (Full),
    .empty    (Empty),
    .count    (Count),
    .overflow (Overflow)
  );

  assign baud_done = (baud_cnt == BAUD_DIV);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    tx_bit  = 1'b1;
    case (state)
      IDLE: begin
        if (!Empty) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_bit = shift[0];
        if (baud_done) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when another byte is waiting.
        if (baud_done) begin
          baud_n = '0;
          if (!Empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Tx is re-timed through a flop, so the line lags the state by one clock.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      Busy     <= 1'b0;
      Tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      Busy     <= (state_n != IDLE);
      Tx       <= tx_bit;
    end
  end

  always_ff @(posedge Clk_100M) begin
    shift <= shift_n;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed an expected-frame queue checked by a line monitor.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk_100M = 1'b0;
  logic          Reset    = 1'b1;
  logic          Wr_En    = 1'b0;
  logic [7:0]    Wr_Data  = 8'h00;
  logic          Full, Empty, Overflow, Busy, Tx;
  logic [CW-1:0] Count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] exp_q[$];
  int         start_q[$];

  logic [99:0] mon_s;
  bit          mon_abort, mon_stable;
  logic [9:0]  mon_got, mon_exp;
  int          mon_start;

  int busy_cnt, lows, diff;

  uart_tx_fifo #(.N(14), .BAUD_DIV(14'd9), .DEPTH(DEPTH)) dut (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .Wr_Data  (Wr_Data),
    .Wr_En    (Wr_En),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Tx       (Tx)
  );

  always #5 Clk_100M = ~Clk_100M;
  always @(posedge Clk_100M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line pattern in transmit order: bit 0 is the start bit, bit 9 the stop bit.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge Clk_100M);
    #1;
  endtask

  // Drives one write strobe across the next edge; Wr_En is left high for back-to-back use.
  task automatic put(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) exp_q.push_back(frame_of(b));
    Wr_Data = b;
    Wr_En   = 1'b1;
    tick();
  endtask

  initial begin : monitor
    forever begin
      @(negedge Clk_100M);
      if (!Reset && Tx === 1'b0) begin
        mon_start = cyc;
        mon_s     = '0;
        mon_abort = 1'b0;
        for (int i = 1; i < 100; i++) begin
          @(negedge Clk_100M);
          if (Reset) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[i] = Tx;
        end
        if (!mon_abort) begin
          mon_stable = 1'b1;
          for (int b = 0; b < 10; b++) begin
            mon_got[b] = mon_s[b*10];
            for (int j = 1; j < 10; j++)
              if (mon_s[b*10+j] !== mon_s[b*10]) mon_stable = 1'b0;
          end
          start_q.push_back(mon_start);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%03h required=no_frame (cycle %0d)", mon_got, cyc);
          end else begin
            mon_exp = exp_q.pop_front();
            if (!mon_stable || mon_got !== mon_exp) begin
              failures++;
              $display("FAIL frame got=%03h stable=%0d required=%03h stable=1", mon_got, mon_stable, mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    repeat (3) tick();
    check("rst_tx", Tx, 1);
    check("rst_busy", Busy, 0);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_count", Count, 0);
    check("rst_overflow", Overflow, 0);
    Reset = 1'b0;
    repeat (2) tick();

    // Single 0x55 frame: latency and Busy duration.
    put(8'h55, 1);
    Wr_En = 1'b0;
    check("lat_empty_fall", Empty, 0);
    tick();
    check("lat_tx_k1", Tx, 1);
    check("lat_busy_k1", Busy, 1);
    tick();
    check("lat_tx_k2", Tx, 0);
    busy_cnt = 2;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (Busy) busy_cnt++;
      else break;
    end
    check("busy_len", busy_cnt, 100);
    repeat (20) tick();
    check("drain_55", exp_q.size(), 0);

    // Two back-to-back frames.
    start_q.delete();
    put(8'h41, 1);
    put(8'h0F, 1);
    Wr_En = 1'b0;
    repeat (230) tick();
    check("b2b_frames", start_q.size(), 2);
    diff = (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1;
    check("b2b_spacing", diff, 100);
    check("drain_b2b", exp_q.size(), 0);

    // Six consecutive writes: one popped, four queued, sixth rejected.
    for (int i = 0; i < 6; i++) begin
      put(8'(i + 1), i < 5);
      if (i == 4) begin
        check("fill_full", Full, 1);
        check("fill_count", Count, 4);
      end
      if (i == 5) begin
        check("ovf_pulse", Overflow, 1);
        check("ovf_count", Count, 4);
      end
    end
    Wr_En = 1'b0;
    tick();
    check("ovf_one_cycle", Overflow, 0);
    repeat (520) tick();
    check("drain_six", exp_q.size(), 0);

    // Full FIFO, write lands on the last STOP clock together with a pop.
    put(8'h81, 1);
    put(8'h3C, 1);
    put(8'hC3, 1);
    put(8'h7E, 1);
    put(8'hA5, 1);
    Wr_En = 1'b0;
    repeat (96) tick();
    check("stop_full", Full, 1);
    check("stop_count", Count, 4);
    put(8'h99, 0);
    Wr_En = 1'b0;
    check("stop_ovf", Overflow, 1);
    check("stop_count_after", Count, 3);
    check("stop_full_after", Full, 0);
    repeat (450) tick();
    check("drain_stop", exp_q.size(), 0);

    // Reset in the middle of a 0xA3 frame with another byte queued.
    put(8'hA3, 0);
    put(8'h77, 0);
    Wr_En = 1'b0;
    repeat (35) tick();
    Reset   = 1'b1;
    Wr_Data = 8'h12;
    Wr_En   = 1'b1;
    tick();
    check("abort_tx", Tx, 1);
    check("abort_busy", Busy, 0);
    check("abort_count", Count, 0);
    check("abort_empty", Empty, 1);
    Reset = 1'b0;
    Wr_En = 1'b0;
    lows = 0;
    repeat (300) begin
      tick();
      if (Tx !== 1'b1) lows++;
    end
    check("abort_quiet", lows, 0);

    // 0xFF: only the start bit is low.
    put(8'hFF, 1);
    Wr_En = 1'b0;
    lows = 0;
    repeat (130) begin
      tick();
      if (Tx === 1'b0) lows++;
    end
    check("ff_low_clocks", lows, 10);
    repeat (10) tick();
    check("drain_ff", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end
endmodule
